// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter
//
// Transmit-side shift engine for the SPI block. Bytes arrive over a
// valid/ready handshake into a one-entry holding buffer, are loaded into a
// shift register, and are serialised one bit per SCLK-enable strobe,
// MSB-first or LSB-first. A buffered byte is chained onto the previous one
// with no idle gap.
//
// Parameters:
//   DATA_WIDTH     bits per transfer word (>= 2)
//   IDLE_LEVEL     level driven on o_serial_out while not shifting
//
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_reset        asynchronous reset, active-high
//   i_sclk_enable  one-cycle strobe per shift edge
//   i_MSB          bit order (1 = MSB-first), sampled when a byte is loaded
//   i_tx_valid     host presents i_tx_data
//   i_tx_data      word to transmit
//   o_tx_ready     holding buffer empty; write accepted on valid && ready
//   o_serial_out   serial data to the pin driver
//   o_shift_active high while a word is being shifted
//   o_byte_done    one-cycle pulse after the last bit of a word

module spi_tx_shifter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_sclk_enable,
    input  logic                  i_MSB,
    input  logic                  i_tx_valid,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    output logic                  o_tx_ready,
    output logic                  o_serial_out,
    output logic                  o_shift_active,
    output logic                  o_byte_done
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  msb_q, msb_d;
    logic                  byte_done_q, byte_done_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  accept;

    // tx_ready_q always mirrors !hold_valid_q, so an accept can never
    // coincide with a load or reload of the shift register.
    assign accept = i_tx_valid && tx_ready_q;

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        msb_d        = msb_q;
        byte_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hold_valid_q) begin
                    shift_d      = hold_data_q;
                    msb_d        = i_MSB;
                    bit_cnt_d    = '0;
                    hold_valid_d = 1'b0;
                    state_d      = StShift;
                end
            end
            StShift: begin
                if (i_sclk_enable) begin
                    if (bit_cnt_q != LastBit) begin
                        shift_d   = msb_q ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                                          : {1'b0, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end else begin
                        byte_done_d = 1'b1;
                        bit_cnt_d   = '0;
                        // Chain the buffered word so its first bit appears
                        // on this same edge.
                        if (hold_valid_q) begin
                            shift_d      = hold_data_q;
                            msb_d        = i_MSB;
                            hold_valid_d = 1'b0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A write landing with the final strobe only becomes visible next
        // cycle, so that word is loaded through StIdle instead of chaining.
        if (accept) begin
            hold_data_d  = i_tx_data;
            hold_valid_d = 1'b1;
        end

        tx_ready_d = !hold_valid_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= StIdle;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            msb_q        <= 1'b1;
            byte_done_q  <= 1'b0;
            tx_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            msb_q        <= msb_d;
            byte_done_q  <= byte_done_d;
            tx_ready_q   <= tx_ready_d;
        end
    end

    // Current bit comes straight off the shift register, so the first bit
    // is already on the line from the load edge onward.
    assign o_serial_out   = (state_q == StShift)
                            ? (msb_q ? shift_q[DATA_WIDTH-1] : shift_q[0])
                            : IDLE_LEVEL;
    assign o_shift_active = (state_q == StShift);
    assign o_byte_done    = byte_done_q;
    assign o_tx_ready     = tx_ready_q;

endmodule

// File: tb/tb_spi_tx_shifter.sv
module tb_spi_tx_shifter;

    logic       i_clk;
    logic       i_reset;
    logic       i_sclk_enable;
    logic       i_MSB;
    logic       i_tx_valid;
    logic [7:0] i_tx_data;
    logic       o_tx_ready;
    logic       o_serial_out;
    logic       o_shift_active;
    logic       o_byte_done;

    spi_tx_shifter #(
        .DATA_WIDTH(8),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_sclk_enable (i_sclk_enable),
        .i_MSB         (i_MSB),
        .i_tx_valid    (i_tx_valid),
        .i_tx_data     (i_tx_data),
        .o_tx_ready    (o_tx_ready),
        .o_serial_out  (o_serial_out),
        .o_shift_active(o_shift_active),
        .o_byte_done   (o_byte_done)
    );

    int n_vec = 0;
    int n_err = 0;

    int strobe_period = 0;

    // Observations gathered by the monitor.
    logic       cap[$];      // bit on the line at each strobe while active
    logic [7:0] acc[$];      // words accepted by the handshake
    int         done_cnt = 0;
    int         active_falls = 0;
    logic       prev_done = 0;
    logic       prev_active = 0;
    logic       prev_strobe_active = 0;

    typedef struct {
        logic [7:0] data;
        logic       msb;
        int         period;
        logic [7:0] bits;    // expected line sequence, first bit at [7]
    } vec_t;

    vec_t vecs[6];

    initial begin
        i_clk = 0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [7:0] b, input logic msb, input int i);
        return msb ? b[7-i] : b[i];
    endfunction

    function automatic logic [7:0] line_seq(input logic [7:0] b, input logic msb);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], bit_of(b, msb, i)};
        return v;
    endfunction

    function automatic logic [7:0] cap_word(input int k);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], cap[8*k+i]};
        return v;
    endfunction

    // Strobe generator: one-cycle pulse every strobe_period clocks.
    initial begin
        int scnt = 0;
        i_sclk_enable = 0;
        forever begin
            @(posedge i_clk);
            #1;
            if (strobe_period <= 0) begin
                i_sclk_enable = 0;
            end else begin
                scnt = (scnt + 1) % strobe_period;
                i_sclk_enable = (scnt == 0);
            end
        end
    end

    // Monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_reset) begin
                if (o_byte_done) begin
                    done_cnt++;
                    chk("done_single_cycle", prev_done, 0);
                    chk("done_after_last_bit", prev_strobe_active, 1);
                    chk("done_on_word_boundary", cap.size() % 8, 0);
                end
                if (prev_active && !o_shift_active) active_falls++;
                if (i_sclk_enable && o_shift_active) cap.push_back(o_serial_out);
                if (i_tx_valid && o_tx_ready) acc.push_back(i_tx_data);
            end
            prev_done          = o_byte_done;
            prev_active        = o_shift_active;
            prev_strobe_active = i_sclk_enable && o_shift_active;
        end
    end

    // Present d and hold it until the handshake takes it; returns at accept edge + 1.
    task automatic send(input logic [7:0] d);
        bit ok = 0;
        @(posedge i_clk);
        #1;
        i_tx_valid = 1;
        i_tx_data  = d;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge i_clk);
            if (o_tx_ready) begin
                @(posedge i_clk);
                #1;
                ok = 1;
            end
        end
        i_tx_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    // Wait until idle with an empty buffer; ends after the monitor has seen that cycle.
    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge i_clk);
            #2;
            if (!o_shift_active && o_tx_ready) ok = 1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(negedge i_clk);
        #1;
    endtask

    initial begin
        int n_before;
        int cap_at_reset;

        vecs[0] = '{8'hC1, 1'b1, 4, 8'b11000001};
        vecs[1] = '{8'hC1, 1'b0, 4, 8'b10000011};
        vecs[2] = '{8'h35, 1'b1, 1, 8'b00110101};
        vecs[3] = '{8'h35, 1'b0, 3, 8'b10101100};
        vecs[4] = '{8'h81, 1'b0, 2, 8'b10000001};
        vecs[5] = '{8'h00, 1'b1, 5, 8'b00000000};

        i_reset    = 1;
        i_MSB      = 1;
        i_tx_valid = 0;
        i_tx_data  = '0;
        #12;
        chk("reset_serial", o_serial_out, 1);
        chk("reset_ready", o_tx_ready, 1);
        chk("reset_active", o_shift_active, 0);
        chk("reset_done", o_byte_done, 0);
        @(posedge i_clk);
        #1;
        i_reset = 0;
        strobe_period = 4;
        repeat (10) @(posedge i_clk);
        #2;
        chk("idle_strobes_ignored", o_shift_active, 0);

        // Table-driven single words.
        for (int k = 0; k < 6; k++) begin
            strobe_period = vecs[k].period;
            i_MSB = vecs[k].msb;
            cap.delete();
            done_cnt = 0;
            send(vecs[k].data);
            chk("accept_ready_low", o_tx_ready, 0);
            @(negedge i_clk);
            chk("still_idle_after_accept", o_shift_active, 0);
            @(negedge i_clk);
            chk("active_after_load", o_shift_active, 1);
            chk("ready_after_load", o_tx_ready, 1);
            chk("first_bit_setup", o_serial_out, vecs[k].bits[7]);
            i_MSB = ~vecs[k].msb;   // must not affect the word in flight
            wait_idle(8 * vecs[k].period + 40);
            chk("vec_bit_count", cap.size(), 8);
            if (cap.size() == 8) chk("vec_bits", cap_word(0), vecs[k].bits);
            chk("vec_done_count", done_cnt, 1);
            chk("vec_idle_level", o_serial_out, 1);
            chk("vec_idle_active", o_shift_active, 0);
        end

        // Back-to-back with backpressure on a third word.
        strobe_period = 4;
        i_MSB = 1;
        cap.delete();
        acc.delete();
        done_cnt = 0;
        active_falls = 0;
        send(8'hC1);
        chk("b2b_ready_low", o_tx_ready, 0);
        send(8'h5A);
        @(posedge i_clk);
        #1;
        i_tx_valid = 1;
        i_tx_data  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            chk("bp_ready_low", o_tx_ready, 0);
        end
        chk("bp_not_accepted", acc.size(), 2);
        send(8'hFF);
        wait_idle(200);
        chk("b2b_bit_count", cap.size(), 24);
        if (cap.size() == 24) begin
            chk("b2b_word0", cap_word(0), 8'hC1);
            chk("b2b_word1", cap_word(1), 8'h5A);
            chk("b2b_word2", cap_word(2), 8'hFF);
        end
        chk("b2b_done_count", done_cnt, 3);
        chk("b2b_no_gap", active_falls, 1);

        // Abort mid-word with a word buffered.
        strobe_period = 4;
        i_MSB = 1;
        cap.delete();
        done_cnt = 0;
        send(8'hC1);
        send(8'h5A);
        chk("abort_buffer_full", o_tx_ready, 0);
        begin
            bit ok = 0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(posedge i_clk);
                if (cap.size() >= 3) ok = 1;
            end
            if (!ok) chk("abort_wait_timeout", 0, 1);
        end
        #2;
        i_reset = 1;
        #1;
        chk("abort_serial", o_serial_out, 1);
        chk("abort_ready", o_tx_ready, 1);
        chk("abort_active", o_shift_active, 0);
        chk("abort_done", o_byte_done, 0);
        cap_at_reset = cap.size();
        @(posedge i_clk);
        #1;
        i_reset = 0;
        repeat (40) @(posedge i_clk);
        #2;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_buffer_dropped", o_shift_active, 0);
        chk("abort_ready_after", o_tx_ready, 1);
        chk("abort_no_bits", cap.size(), cap_at_reset);
        cap.delete();
        send(8'h81);
        wait_idle(100);
        chk("post_abort_count", cap.size(), 8);
        if (cap.size() == 8) chk("post_abort_bits", cap_word(0), 8'b10000001);
        chk("post_abort_done", done_cnt, 1);

        // Randomised batches against the word-stream model.
        for (int b = 0; b < 8; b++) begin
            logic msb;
            int   nbytes;
            msb = 1'($urandom_range(0, 1));
            i_MSB = msb;
            strobe_period = $urandom_range(1, 5);
            nbytes = $urandom_range(3, 8);
            cap.delete();
            acc.delete();
            done_cnt = 0;
            n_before = 0;
            for (int j = 0; j < nbytes; j++) begin
                repeat ($urandom_range(0, 15)) @(posedge i_clk);
                send(8'($urandom));
            end
            wait_idle(400);
            chk("rnd_accept_count", acc.size(), nbytes);
            chk("rnd_bit_count", cap.size(), 8 * acc.size());
            chk("rnd_done_count", done_cnt, acc.size());
            if (cap.size() == 8 * acc.size()) begin
                for (int k = 0; k < acc.size(); k++)
                    chk("rnd_word", cap_word(k), line_seq(acc[k], msb));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
